// File: rtl/mem_rd_ctrl_pkg.sv
// Shared types and defaults for the read-bus controller: controller state, access source
// and the timeout helper.
package mem_rd_ctrl_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefAw    = 32;
    localparam int unsigned DefTow   = 8;

    typedef enum logic {
        StIdle = 1'b0,
        StBus  = 1'b1
    } state_e;

    typedef enum logic {
        SrcIf = 1'b0,
        SrcLd = 1'b1
    } src_e;

    // Number of ack-less bus cycles after which an access is abandoned.
    function automatic int unsigned timeout_cycles(input int unsigned tow);
        return (32'd1 << tow) - 32'd1;
    endfunction

endpackage

// File: rtl/mem_rd_ctrl_bus_timer.sv
// Bus-access watchdog: TOW-bit counter with synchronous clear and enable. 'last' flags the
// final cycle before the timeout count would be reached.
module bus_timer
    import mem_rd_ctrl_pkg::*;
#(
    parameter int unsigned TOW = DefTow
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clr,
    input  logic           en,
    output logic [TOW-1:0] count,
    output logic           last
);

    localparam logic [TOW-1:0] LastVal = TOW'(timeout_cycles(TOW) - 1);

    logic [TOW-1:0] count_q;
    logic [TOW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + TOW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == LastVal);

endmodule

// File: rtl/mem_rd_ctrl.sv
// Arbitrates fetch and load read requests onto one external read bus and returns the word
// on dout with a per-source one-cycle write strobe for the holding register.
module mem_rd_ctrl
    import mem_rd_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned AW    = DefAw,
    parameter int unsigned TOW   = DefTow
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             if_req,
    input  logic [AW-1:0]    if_addr,
    input  logic             ld_req,
    input  logic [AW-1:0]    ld_addr,
    output logic             mem_rd,
    output logic [AW-1:0]    mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] dout,
    output logic             wen1,
    output logic             wen2,
    output logic             if_done,
    output logic             ld_done,
    output logic             busy,
    output logic             err
);

    state_e           state_q, state_d;
    src_e             src_q, src_d;
    logic             mem_rd_q, mem_rd_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             wen1_q, wen1_d;
    logic             wen2_q, wen2_d;
    logic             if_done_q, if_done_d;
    logic             ld_done_q, ld_done_d;
    logic             err_q, err_d;

    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_last;
    logic [TOW-1:0]   tmr_count;

    assign tmr_clr = (state_q == StIdle);
    assign tmr_en  = (state_q == StBus) && !mem_ack;

    bus_timer #(
        .TOW (TOW)
    ) u_bus_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .count   (tmr_count),
        .last    (tmr_last)
    );

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        mem_rd_d   = mem_rd_q;
        mem_addr_d = mem_addr_q;
        dout_d     = dout_q;
        err_d      = err_q;
        wen1_d     = 1'b0;
        wen2_d     = 1'b0;
        if_done_d  = 1'b0;
        ld_done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                // The cycle a done pulse is visible gives the requester time to drop req.
                if (!if_done_q && !ld_done_q) begin
                    if (ld_req) begin
                        state_d    = StBus;
                        src_d      = SrcLd;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = ld_addr;
                        err_d      = 1'b0;
                    end else if (if_req) begin
                        state_d    = StBus;
                        src_d      = SrcIf;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = if_addr;
                        err_d      = 1'b0;
                    end
                end
            end
            StBus: begin
                if (mem_ack) begin
                    dout_d   = mem_rdata;
                    mem_rd_d = 1'b0;
                    state_d  = StIdle;
                    if (src_q == SrcLd) begin
                        wen2_d    = 1'b1;
                        ld_done_d = 1'b1;
                    end else begin
                        wen1_d    = 1'b1;
                        if_done_d = 1'b1;
                    end
                end else if (tmr_last) begin
                    // Timeout: release the requester without a write strobe.
                    mem_rd_d = 1'b0;
                    state_d  = StIdle;
                    err_d    = 1'b1;
                    if (src_q == SrcLd) begin
                        ld_done_d = 1'b1;
                    end else begin
                        if_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = StIdle;
                mem_rd_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            src_q      <= SrcIf;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            dout_q     <= '0;
            wen1_q     <= 1'b0;
            wen2_q     <= 1'b0;
            if_done_q  <= 1'b0;
            ld_done_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            dout_q     <= dout_d;
            wen1_q     <= wen1_d;
            wen2_q     <= wen2_d;
            if_done_q  <= if_done_d;
            ld_done_q  <= ld_done_d;
            err_q      <= err_d;
        end
    end

    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign dout     = dout_q;
    assign wen1     = wen1_q;
    assign wen2     = wen2_q;
    assign if_done  = if_done_q;
    assign ld_done  = ld_done_q;
    assign busy     = (state_q == StBus);
    assign err      = err_q;

    // The holding register must never see both write enables in one cycle.
    a_wen_onehot : assert property (@(posedge clk) disable iff (!reset_n) !(wen1_q && wen2_q));

    // The counter value itself is only consumed through 'last'.
    logic unused_tmr;
    assign unused_tmr = ^tmr_count;

endmodule

// File: tb/tb_mem_rd_ctrl.sv
// Self-checking bench for mem_rd_ctrl: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level reference model.
module tb_mem_rd_ctrl;

    localparam int TOW      = 4;
    localparam int TIMEOUT  = (1 << TOW) - 1;
    localparam int N_RAND   = 3000;

    logic        clk;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] dout;
    logic        wen1;
    logic        wen2;
    logic        if_done;
    logic        ld_done;
    logic        busy;
    logic        err;

    mem_rd_ctrl #(
        .WIDTH (32),
        .AW    (32),
        .TOW   (TOW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .dout      (dout),
        .wen1      (wen1),
        .wen2      (wen2),
        .if_done   (if_done),
        .ld_done   (ld_done),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] ex(input logic rd, input logic [31:0] ad,
                                       input logic [31:0] dt, input logic w1, input logic w2,
                                       input logic fd, input logic ldn, input logic bs,
                                       input logic er);
        return {rd, ad, dt, w1, w2, fd, ldn, bs, er};
    endfunction

    function automatic logic [71:0] outs();
        return {mem_rd, mem_addr, dout, wen1, wen2, if_done, ld_done, busy, err};
    endfunction

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        lr;
        logic [31:0] la;
        logic        ak;
        logic [31:0] rd;
        logic [71:0] exp;
    } vec_t;

    function automatic vec_t v(input logic ir, input logic [31:0] ia, input logic lr,
                               input logic [31:0] la, input logic ak, input logic [31:0] rd,
                               input logic [71:0] e);
        vec_t r;
        r.ir = ir; r.ia = ia; r.lr = lr; r.la = la; r.ak = ak; r.rd = rd; r.exp = e;
        return r;
    endfunction

    // Reference model: an access lasts until ack or until TIMEOUT ack-less bus cycles.
    logic        e_busy, e_src_ld, e_rd, e_w1, e_w2, e_ifd, e_ldd, e_err;
    logic [31:0] e_maddr, e_dout;
    int          e_cnt;

    task automatic model_reset();
        e_busy = 0; e_src_ld = 0; e_rd = 0; e_w1 = 0; e_w2 = 0; e_ifd = 0; e_ldd = 0;
        e_err = 0; e_maddr = 0; e_dout = 0; e_cnt = 0;
    endtask

    task automatic model_step();
        bit pend_done;
        pend_done = e_ifd || e_ldd;
        e_w1 = 0; e_w2 = 0; e_ifd = 0; e_ldd = 0;
        if (!e_busy) begin
            if (!pend_done && (ld_req || if_req)) begin
                e_busy   = 1;
                e_src_ld = ld_req;
                e_maddr  = ld_req ? ld_addr : if_addr;
                e_cnt    = 0;
                e_err    = 0;
            end
        end else begin
            e_cnt++;
            if (mem_ack) begin
                e_dout = mem_rdata;
                if (e_src_ld) begin e_w2 = 1; e_ldd = 1; end
                else          begin e_w1 = 1; e_ifd = 1; end
                e_busy = 0;
            end else if (e_cnt == TIMEOUT) begin
                if (e_src_ld) e_ldd = 1;
                else          e_ifd = 1;
                e_err  = 1;
                e_busy = 0;
            end
        end
        e_rd = e_busy;
    endtask

    vec_t tbl[19];

    initial begin
        int n;
        bit saw_wen;

        tbl[0]  = v(1, 32'h100, 0, 0, 0, 0,            ex(1, 32'h100, 0, 0, 0, 0, 0, 1, 0));
        tbl[1]  = v(1, 32'h100, 0, 0, 0, 0,            ex(1, 32'h100, 0, 0, 0, 0, 0, 1, 0));
        tbl[2]  = v(1, 32'h100, 0, 0, 0, 0,            ex(1, 32'h100, 0, 0, 0, 0, 0, 1, 0));
        tbl[3]  = v(1, 32'h100, 0, 0, 1, 32'hDEADBEEF,
                    ex(0, 32'h100, 32'hDEADBEEF, 1, 0, 1, 0, 0, 0));
        tbl[4]  = v(0, 0, 0, 0, 0, 0,                  ex(0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0));
        tbl[5]  = v(1, 32'h100, 1, 32'h200, 0, 0,      ex(1, 32'h200, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0));
        tbl[6]  = v(1, 32'h100, 1, 32'h200, 1, 32'h11112222,
                    ex(0, 32'h200, 32'h11112222, 0, 1, 0, 1, 0, 0));
        tbl[7]  = v(1, 32'h100, 0, 0, 0, 0,            ex(0, 32'h200, 32'h11112222, 0, 0, 0, 0, 0, 0));
        tbl[8]  = v(1, 32'h100, 0, 0, 0, 0,            ex(1, 32'h100, 32'h11112222, 0, 0, 0, 0, 1, 0));
        tbl[9]  = v(1, 32'h100, 0, 0, 1, 32'h33334444,
                    ex(0, 32'h100, 32'h33334444, 1, 0, 1, 0, 0, 0));
        tbl[10] = v(1, 32'h104, 0, 0, 0, 0,            ex(0, 32'h100, 32'h33334444, 0, 0, 0, 0, 0, 0));
        tbl[11] = v(1, 32'h104, 0, 0, 1, 32'h99999999, ex(1, 32'h104, 32'h33334444, 0, 0, 0, 0, 1, 0));
        tbl[12] = v(1, 32'h104, 0, 0, 1, 32'h55,       ex(0, 32'h104, 32'h55, 1, 0, 1, 0, 0, 0));
        tbl[13] = v(1, 32'h108, 0, 0, 0, 0,            ex(0, 32'h104, 32'h55, 0, 0, 0, 0, 0, 0));
        tbl[14] = v(1, 32'h108, 0, 0, 0, 0,            ex(1, 32'h108, 32'h55, 0, 0, 0, 0, 1, 0));
        tbl[15] = v(1, 32'h108, 0, 0, 1, 32'h66,       ex(0, 32'h108, 32'h66, 1, 0, 1, 0, 0, 0));
        tbl[16] = v(0, 0, 0, 0, 1, 32'h77,             ex(0, 32'h108, 32'h66, 0, 0, 0, 0, 0, 0));
        tbl[17] = v(0, 0, 0, 0, 1, 32'h88,             ex(0, 32'h108, 32'h66, 0, 0, 0, 0, 0, 0));
        tbl[18] = v(0, 0, 0, 0, 0, 0,                  ex(0, 32'h108, 32'h66, 0, 0, 0, 0, 0, 0));

        reset_n = 0; if_req = 0; if_addr = 0; ld_req = 0; ld_addr = 0;
        mem_ack = 0; mem_rdata = 0;
        #12;
        chk("reset_state", outs(), 72'd0);
        @(negedge clk);
        reset_n = 1;

        for (int i = 0; i < 19; i++) begin
            if_req = tbl[i].ir; if_addr = tbl[i].ia;
            ld_req = tbl[i].lr; ld_addr = tbl[i].la;
            mem_ack = tbl[i].ak; mem_rdata = tbl[i].rd;
            tick();
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // Load timeout: done after TIMEOUT bus cycles, error set, no strobe, dout kept.
        ld_req = 1; ld_addr = 32'h300; mem_ack = 0; if_req = 0;
        tick();
        chk("to_start", 72'({mem_rd, mem_addr, busy, err}), 72'({1'b1, 32'h300, 1'b1, 1'b0}));
        saw_wen = 0;
        for (n = 1; n <= 40; n++) begin
            tick();
            if (wen1 || wen2) saw_wen = 1;
            if (ld_done) break;
        end
        chk("to_len", 72'(n), 72'(TIMEOUT));
        chk("to_err", 72'(err), 72'd1);
        chk("to_dout", 72'(dout), 72'(32'h66));
        chk("to_nowen", 72'({saw_wen, wen2, mem_rd, busy}), 72'd0);
        ld_req = 0;
        tick();
        chk("to_sticky", 72'({err, busy}), 72'({1'b1, 1'b0}));
        if_req = 1; if_addr = 32'h400;
        tick();
        chk("to_clear", 72'({err, mem_rd, mem_addr}), 72'({1'b0, 1'b1, 32'h400}));
        mem_ack = 1; mem_rdata = 32'hA5A5A5A5;
        tick();
        chk("after_to", 72'({wen1, if_done, dout}), 72'({1'b1, 1'b1, 32'hA5A5A5A5}));
        if_req = 0; mem_ack = 0;
        tick();

        // Asynchronous reset in the second bus cycle.
        if_req = 1; if_addr = 32'h500;
        tick();
        chk("rst_enter", 72'({mem_rd, mem_addr}), 72'({1'b1, 32'h500}));
        tick();
        #2;
        reset_n = 0;
        #1;
        chk("rst_async", 72'({mem_rd, busy, dout, err, mem_addr}), 72'd0);
        if_req = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_quiet%0d", i), 72'({wen1, wen2, if_done, ld_done, mem_rd}), 72'd0);
        end
        ld_req = 1; ld_addr = 32'h600;
        tick();
        chk("rst_new_req", 72'({mem_rd, mem_addr}), 72'({1'b1, 32'h600}));
        mem_ack = 1; mem_rdata = 32'hCAFEF00D;
        tick();
        chk("rst_new_data", 72'({wen2, ld_done, wen1, dout}), 72'({3'b110, 32'hCAFEF00D}));
        ld_req = 0; mem_ack = 0;
        tick();

        // Randomized traffic against the reference model.
        reset_n = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        for (int c = 0; c < N_RAND; c++) begin
            mem_ack   = ($urandom_range(4, 0) == 0);
            mem_rdata = $urandom;
            model_step();
            tick();
            chk($sformatf("rand%0d", c), outs(),
                ex(e_rd, e_maddr, e_dout, e_w1, e_w2, e_ifd, e_ldd, e_busy, e_err));
            if (if_req) begin
                if (e_ifd && $urandom_range(1, 0) == 1) if_req = 0;
                else if (e_busy && !e_src_ld && $urandom_range(63, 0) == 0) if_req = 0;
            end else if ($urandom_range(3, 0) == 0) begin
                if_req = 1; if_addr = $urandom;
            end
            if (ld_req) begin
                if (e_ldd && $urandom_range(1, 0) == 1) ld_req = 0;
            end else if ($urandom_range(5, 0) == 0) begin
                ld_req = 1; ld_addr = $urandom;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
